// File: rtl/rect_write_arbiter.sv
// Round-robin arbiter for the vga_pipeline rectangle-table write port.
// Range-checks each granted request and can hold grants off until frame_safe is high.
module rect_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int WIDTHBITS  = 10,
    parameter int HEIGHTBITS = 10,
    parameter int COLORBITS  = 8,
    parameter int RECTBITS   = 6,
    parameter int FRAME_SYNC = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*COLORBITS-1:0]  req_color_i,
    input  logic [NREQ-1:0]            req_enabled_i,
    input  logic [NREQ*WIDTHBITS-1:0]  req_x1_i,
    input  logic [NREQ*WIDTHBITS-1:0]  req_x2_i,
    input  logic [NREQ*HEIGHTBITS-1:0] req_y1_i,
    input  logic [NREQ*HEIGHTBITS-1:0] req_y2_i,
    input  logic [NREQ*RECTBITS-1:0]   req_index_i,
    input  logic                       frame_safe_i,
    output logic [NREQ-1:0]            ack_o,
    output logic [NREQ-1:0]            err_o,
    output logic                       busy_o,
    output logic [COLORBITS-1:0]       st__conf_color_o,
    output logic                       st__conf_enabled_o,
    output logic [WIDTHBITS-1:0]       st__conf_rect_x1_o,
    output logic [WIDTHBITS-1:0]       st__conf_rect_x2_o,
    output logic [HEIGHTBITS-1:0]      st__conf_rect_y1_o,
    output logic [HEIGHTBITS-1:0]      st__conf_rect_y2_o,
    output logic [RECTBITS-1:0]        vg__rect_index_o,
    output logic                       vg__rect_write_o
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTHBITS:0]  WIDTH_L  = (WIDTHBITS+1)'(WIDTH);
    localparam logic [HEIGHTBITS:0] HEIGHT_L = (HEIGHTBITS+1)'(HEIGHT);

    typedef enum logic [1:0] {IDLE, WRITE, REJECT, DONE} state_t;

    state_t                 state_q;
    logic [RRW-1:0]         rr_last_q;
    logic [RRW-1:0]         gnt_q;
    logic [NREQ-1:0]        ack_q;
    logic [NREQ-1:0]        err_q;
    logic                   write_q;
    logic [COLORBITS-1:0]   color_q;
    logic                   enabled_q;
    logic [WIDTHBITS-1:0]   x1_q, x2_q;
    logic [HEIGHTBITS-1:0]  y1_q, y2_q;
    logic [RECTBITS-1:0]    index_q;

    logic [RRW-1:0]         gnt_d;
    logic                   found_d;
    logic                   grant_d;
    logic                   valid_d;
    logic [COLORBITS-1:0]   sel_color;
    logic [WIDTHBITS-1:0]   sel_x1, sel_x2;
    logic [HEIGHTBITS-1:0]  sel_y1, sel_y2;
    logic [RECTBITS-1:0]    sel_index;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        found_d = 1'b0;
        gnt_d   = rr_last_q;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_last_q) + i) % NREQ;
            if (!found_d && req_i[idx]) begin
                found_d = 1'b1;
                gnt_d   = RRW'(idx);
            end
        end
    end

    assign sel_color = req_color_i[gnt_d*COLORBITS +: COLORBITS];
    assign sel_x1    = req_x1_i[gnt_d*WIDTHBITS +: WIDTHBITS];
    assign sel_x2    = req_x2_i[gnt_d*WIDTHBITS +: WIDTHBITS];
    assign sel_y1    = req_y1_i[gnt_d*HEIGHTBITS +: HEIGHTBITS];
    assign sel_y2    = req_y2_i[gnt_d*HEIGHTBITS +: HEIGHTBITS];
    assign sel_index = req_index_i[gnt_d*RECTBITS +: RECTBITS];

    assign grant_d = found_d && ((FRAME_SYNC == 0) || frame_safe_i);
    assign valid_d = (sel_x1 <= sel_x2) && (sel_y1 <= sel_y2) &&
                     ({1'b0, sel_x2} < WIDTH_L) && ({1'b0, sel_y2} < HEIGHT_L);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_last_q <= RRW'(NREQ-1);
            gnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            write_q   <= 1'b0;
            color_q   <= '0;
            enabled_q <= 1'b0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            index_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        rr_last_q <= gnt_d;
                        gnt_q     <= gnt_d;
                        color_q   <= sel_color;
                        enabled_q <= req_enabled_i[gnt_d];
                        x1_q      <= sel_x1;
                        x2_q      <= sel_x2;
                        y1_q      <= sel_y1;
                        y2_q      <= sel_y2;
                        index_q   <= sel_index;
                        if (valid_d) begin
                            write_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            err_q   <= NREQ'(1) << gnt_d;
                            state_q <= REJECT;
                        end
                    end
                end
                WRITE: begin
                    write_q <= 1'b0;
                    ack_q   <= NREQ'(1) << gnt_q;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                REJECT: begin
                    err_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o              = ack_q;
    assign err_o              = err_q;
    assign busy_o             = (state_q != IDLE);
    assign st__conf_color_o   = color_q;
    assign st__conf_enabled_o = enabled_q;
    assign st__conf_rect_x1_o = x1_q;
    assign st__conf_rect_x2_o = x2_q;
    assign st__conf_rect_y1_o = y1_q;
    assign st__conf_rect_y2_o = y2_q;
    assign vg__rect_index_o   = index_q;
    assign vg__rect_write_o   = write_q;

endmodule

// File: tb/tb_rect_write_arbiter.sv
// Directed bench for rect_write_arbiter: grant order, latency, range rejects,
// frame gating and asynchronous reset abort.
module tb_rect_write_arbiter;

    localparam int NREQ = 4;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*8-1:0]   req_color;
    logic [NREQ-1:0]     req_enabled;
    logic [NREQ*10-1:0]  req_x1, req_x2;
    logic [NREQ*10-1:0]  req_y1, req_y2;
    logic [NREQ*6-1:0]   req_index;
    logic                frame_safe;
    logic [NREQ-1:0]     ack, err;
    logic                busy;
    logic [7:0]          conf_color;
    logic                conf_enabled;
    logic [9:0]          conf_x1, conf_x2, conf_y1, conf_y2;
    logic [5:0]          rect_index;
    logic                rect_write;

    int checks = 0;
    int errors = 0;

    rect_write_arbiter dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .req_color_i        (req_color),
        .req_enabled_i      (req_enabled),
        .req_x1_i           (req_x1),
        .req_x2_i           (req_x2),
        .req_y1_i           (req_y1),
        .req_y2_i           (req_y2),
        .req_index_i        (req_index),
        .frame_safe_i       (frame_safe),
        .ack_o              (ack),
        .err_o              (err),
        .busy_o             (busy),
        .st__conf_color_o   (conf_color),
        .st__conf_enabled_o (conf_enabled),
        .st__conf_rect_x1_o (conf_x1),
        .st__conf_rect_x2_o (conf_x2),
        .st__conf_rect_y1_o (conf_y1),
        .st__conf_rect_y2_o (conf_y2),
        .vg__rect_index_o   (rect_index),
        .vg__rect_write_o   (rect_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [7:0] c, input logic en,
                              input logic [9:0] x1, input logic [9:0] x2,
                              input logic [9:0] y1, input logic [9:0] y2,
                              input logic [5:0] idx);
        req_color[i*8 +: 8]   = c;
        req_enabled[i]        = en;
        req_x1[i*10 +: 10]    = x1;
        req_x2[i*10 +: 10]    = x2;
        req_y1[i*10 +: 10]    = y1;
        req_y2[i*10 +: 10]    = y2;
        req_index[i*6 +: 6]   = idx;
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        req_color   = '0;
        req_enabled = '0;
        req_x1      = '0;
        req_x2      = '0;
        req_y1      = '0;
        req_y2      = '0;
        req_index   = '0;
        frame_safe  = 1'b1;
        #1;
        chk("reset_ack", 64'(ack), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_write", 64'(rect_write), 64'h0);
        chk("reset_index", 64'(rect_index), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Round-robin: all four requesting, each drops at ack and re-raises next cycle.
        for (int i = 0; i < NREQ; i++)
            set_fields(i, 8'(8'h10 + i), 1'b1, 10'(i), 10'(100 + i), 10'(i), 10'(50 + i), 6'(8 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NREQ;
            tick();
            chk("rr_write", 64'(rect_write), 64'h1);
            chk("rr_index", 64'(rect_index), 64'(8 + g));
            chk("rr_color", 64'(conf_color), 64'(8'h10 + g));
            chk("rr_x2", 64'(conf_x2), 64'(100 + g));
            tick();
            chk("rr_ack", 64'(ack), 64'(4'b0001 << g));
            chk("rr_write_off", 64'(rect_write), 64'h0);
            req[g] = 1'b0;
            tick();
            chk("rr_idle", 64'(busy), 64'h0);
            chk("rr_ack_off", 64'(ack), 64'h0);
            req[g] = 1'b1;
        end
        req = '0;
        tick();

        // Single request on requester 2.
        set_fields(2, 8'hE0, 1'b1, 10'd0, 10'd399, 10'd0, 10'd299, 6'd5);
        req = 4'b0100;
        tick();
        chk("single_write", 64'(rect_write), 64'h1);
        chk("single_busy", 64'(busy), 64'h1);
        chk("single_color", 64'(conf_color), 64'hE0);
        chk("single_en", 64'(conf_enabled), 64'h1);
        chk("single_x1", 64'(conf_x1), 64'd0);
        chk("single_x2", 64'(conf_x2), 64'd399);
        chk("single_y1", 64'(conf_y1), 64'd0);
        chk("single_y2", 64'(conf_y2), 64'd299);
        chk("single_index", 64'(rect_index), 64'd5);
        chk("single_ack_early", 64'(ack), 64'h0);
        tick();
        chk("single_ack", 64'(ack), 64'b0100);
        chk("single_write_off", 64'(rect_write), 64'h0);
        req = '0;
        tick();
        chk("single_done_idle", 64'(busy), 64'h0);
        chk("single_hold_color", 64'(conf_color), 64'hE0);
        chk("single_hold_x2", 64'(conf_x2), 64'd399);

        // Rejects on requester 1: inverted x, then y2 at HEIGHT.
        set_fields(1, 8'h33, 1'b1, 10'd500, 10'd400, 10'd0, 10'd10, 6'd7);
        req = 4'b0010;
        tick();
        chk("rej_x_err", 64'(err), 64'b0010);
        chk("rej_x_write", 64'(rect_write), 64'h0);
        chk("rej_x_ack", 64'(ack), 64'h0);
        chk("rej_x_latched", 64'(conf_x1), 64'd500);
        req = '0;
        tick();
        chk("rej_x_idle", 64'(busy), 64'h0);
        chk("rej_x_err_off", 64'(err), 64'h0);
        set_fields(1, 8'h33, 1'b1, 10'd0, 10'd10, 10'd0, 10'd600, 6'd7);
        req = 4'b0010;
        tick();
        chk("rej_y_err", 64'(err), 64'b0010);
        chk("rej_y_write", 64'(rect_write), 64'h0);
        req = '0;
        tick();
        chk("rej_y_write_after", 64'(rect_write), 64'h0);
        chk("rej_y_ack_after", 64'(ack), 64'h0);

        // Boundary: one-pixel rect at the far corner, then x2 one past the edge.
        set_fields(0, 8'hAA, 1'b0, 10'd799, 10'd799, 10'd599, 10'd599, 6'd63);
        req = 4'b0001;
        tick();
        chk("bnd_ok_write", 64'(rect_write), 64'h1);
        chk("bnd_ok_index", 64'(rect_index), 64'd63);
        chk("bnd_ok_en", 64'(conf_enabled), 64'h0);
        chk("bnd_ok_err", 64'(err), 64'h0);
        tick();
        chk("bnd_ok_ack", 64'(ack), 64'b0001);
        req = '0;
        tick();
        set_fields(0, 8'hAA, 1'b0, 10'd799, 10'd800, 10'd599, 10'd599, 6'd63);
        req = 4'b0001;
        tick();
        chk("bnd_bad_err", 64'(err), 64'b0001);
        chk("bnd_bad_write", 64'(rect_write), 64'h0);
        req = '0;
        tick();

        // Frame gate: no grant while frame_safe is low; completes after it falls.
        frame_safe = 1'b0;
        set_fields(3, 8'h5C, 1'b1, 10'd20, 10'd40, 10'd30, 10'd60, 6'd12);
        req = 4'b1000;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("gate_busy", 64'(busy), 64'h0);
            chk("gate_write", 64'(rect_write), 64'h0);
        end
        frame_safe = 1'b1;
        tick();
        chk("gate_write_on", 64'(rect_write), 64'h1);
        chk("gate_index", 64'(rect_index), 64'd12);
        frame_safe = 1'b0;
        tick();
        chk("gate_ack", 64'(ack), 64'b1000);
        req = '0;
        tick();
        frame_safe = 1'b1;

        // Reset asserted mid-WRITE aborts the transaction.
        set_fields(1, 8'h77, 1'b1, 10'd1, 10'd2, 10'd3, 10'd4, 6'd9);
        req = 4'b0010;
        tick();
        chk("rst_pre_write", 64'(rect_write), 64'h1);
        rst = 1'b1;
        #1;
        chk("rst_write_drop", 64'(rect_write), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_color", 64'(conf_color), 64'h0);
        chk("rst_index", 64'(rect_index), 64'h0);
        chk("rst_x2", 64'(conf_x2), 64'h0);
        req = '0;
        tick();
        chk("rst_held_ack", 64'(ack), 64'h0);
        rst = 1'b0;
        tick();
        chk("rst_no_ack", 64'(ack), 64'h0);
        chk("rst_no_err", 64'(err), 64'h0);
        set_fields(0, 8'h01, 1'b1, 10'd5, 10'd6, 10'd7, 10'd8, 6'd2);
        req = 4'b0001;
        tick();
        chk("post_rst_write", 64'(rect_write), 64'h1);
        chk("post_rst_index", 64'(rect_index), 64'd2);
        tick();
        chk("post_rst_ack", 64'(ack), 64'b0001);
        req = '0;
        tick();
        chk("post_rst_idle", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
